// File: rtl/inv_mix_col.sv
// AES InvMixColumns over a 128-bit state, one column per clock with a start/done handshake.
// Optional build macro INV_MIX_COL_PARALLEL_EN: all four columns computed in a single cycle.
module inv_mix_col #(
    parameter logic [3:0] BYPASS_ROUND = 4'd0
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start,
    input  logic [127:0] data_in,
    input  logic [3:0]   count_in,
    output logic         busy,
    output logic         done,
    output logic [127:0] data_out
);

    // state  | meaning
    // IDLE   | waiting for start
    // BYPASS | final decrypt round, captured state passed through unmixed
    // COL    | mixing columns
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BYPASS = 2'd1,
        COL    = 2'd2
    } state_t;

    state_t       state;
    logic [127:0] state_reg;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Coefficients 9/11/13/14 built from the x2/x4/x8 chain of each byte.
    function automatic logic [31:0] inv_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] m11 [4];
        logic [7:0] m13 [4];
        logic [7:0] m14 [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]   = col[31-8*i -: 8];
            x2     = xt(a[i]);
            x4     = xt(x2);
            x8     = xt(x4);
            m9[i]  = x8 ^ a[i];
            m11[i] = x8 ^ x2 ^ a[i];
            m13[i] = x8 ^ x4 ^ a[i];
            m14[i] = x8 ^ x4 ^ x2;
        end
        return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
                m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
                m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
                m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
    endfunction

`ifdef INV_MIX_COL_PARALLEL_EN

    logic [127:0] mixed_all;

    assign mixed_all = {inv_col(state_reg[127:96]), inv_col(state_reg[95:64]),
                        inv_col(state_reg[63:32]),  inv_col(state_reg[31:0])};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            state_reg <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            data_out  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state_reg <= data_in;
                        busy      <= 1'b1;
                        state     <= (count_in == BYPASS_ROUND) ? BYPASS : COL;
                    end
                end
                BYPASS: begin
                    data_out <= state_reg;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                COL: begin
                    data_out <= mixed_all;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`else

    logic [1:0]  col_cnt;
    logic [31:0] col_sel;
    logic [31:0] col_mixed;

    always_comb begin
        col_sel = state_reg[127:96];
        case (col_cnt)
            2'd0: col_sel = state_reg[127:96];
            2'd1: col_sel = state_reg[95:64];
            2'd2: col_sel = state_reg[63:32];
            2'd3: col_sel = state_reg[31:0];
            default: col_sel = state_reg[127:96];
        endcase
    end

    assign col_mixed = inv_col(col_sel);

    // Mixed columns are written back in place, so column 3's edge sees cols 0-2 already done.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            state_reg <= '0;
            col_cnt   <= 2'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            data_out  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state_reg <= data_in;
                        col_cnt   <= 2'd0;
                        busy      <= 1'b1;
                        state     <= (count_in == BYPASS_ROUND) ? BYPASS : COL;
                    end
                end
                BYPASS: begin
                    data_out <= state_reg;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                COL: begin
                    case (col_cnt)
                        2'd0: state_reg[127:96] <= col_mixed;
                        2'd1: state_reg[95:64]  <= col_mixed;
                        2'd2: state_reg[63:32]  <= col_mixed;
                        2'd3: state_reg[31:0]   <= col_mixed;
                        default: ;
                    endcase
                    col_cnt <= col_cnt + 2'd1;
                    if (col_cnt == 2'd3) begin
                        data_out <= {state_reg[127:32], col_mixed};
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`endif

endmodule
